// File: rtl/fir_out_requant_if.sv
// AXI-Stream bundle used for both the wide FIR input and the narrow requantized output.
interface fir_out_requant_if #(
    parameter int unsigned DATA_W = 16
);
    localparam int unsigned KEEP_W = DATA_W / 8;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input  tready);
    modport slave  (input  tdata, input  tkeep, input  tlast, input  tvalid, output tready);
endinterface

// File: rtl/fir_out_requant.sv
// Rounds/saturates Q30 FIR output beats to Q15 and buffers them in a small FIFO
// ahead of a 16-bit AXI-Stream, with saturation and frame statistics.
module fir_out_requant #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 15,
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    fir_out_requant_if.slave        s_axis,
    fir_out_requant_if.master       m_axis,
    output logic [$clog2(DEPTH):0]  level,
    output logic [15:0]             sat_count,
    output logic [15:0]             frame_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned T_W   = IN_W + 1;

    localparam logic signed [T_W-1:0] RND   = T_W'(2 ** (SHIFT - 1));
    localparam logic signed [T_W-1:0] MAX_R = T_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [T_W-1:0] MIN_R = T_W'(-(2 ** (OUT_W - 1)));

    typedef struct packed {
        logic             last;
        logic [OUT_W-1:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             tready_q;
    logic             tvalid_q;

    logic             push_c;
    logic             pop_c;
    logic [LVL_W-1:0] level_nxt_c;
    logic signed [T_W-1:0] t_c;
    logic signed [T_W-1:0] r_c;
    logic [OUT_W-1:0] q_c;
    logic             sat_c;
    logic             unused_keep_c;

    assign unused_keep_c = ^s_axis.tkeep;

    assign push_c      = s_axis.tvalid && tready_q;
    assign pop_c       = tvalid_q && m_axis.tready;
    assign level_nxt_c = level + LVL_W'(push_c) - LVL_W'(pop_c);

    // Round half toward +inf, then clamp to the signed output range.
    always_comb begin
        t_c   = T_W'(signed'(s_axis.tdata)) + RND;
        r_c   = t_c >>> SHIFT;
        q_c   = r_c[OUT_W-1:0];
        sat_c = 1'b0;
        if (r_c > MAX_R) begin
            q_c   = {1'b0, {(OUT_W-1){1'b1}}};
            sat_c = 1'b1;
        end else if (r_c < MIN_R) begin
            q_c   = {1'b1, {(OUT_W-1){1'b0}}};
            sat_c = 1'b1;
        end
    end

    // FIFO storage, pointers, occupancy and registered handshake flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            tready_q <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= '{last: s_axis.tlast, data: q_c};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level    <= level_nxt_c;
            tready_q <= (level_nxt_c != LVL_W'(DEPTH));
            tvalid_q <= (level_nxt_c != '0);
        end
    end

    // Statistics: saturations stick at all-ones, delivered frames wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_count   <= '0;
            frame_count <= '0;
        end else begin
            if (push_c && sat_c && (sat_count != 16'hFFFF)) begin
                sat_count <= sat_count + 16'd1;
            end
            if (pop_c && mem[rd_ptr].last) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    assign s_axis.tready = tready_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = mem[rd_ptr].data;
    assign m_axis.tlast  = mem[rd_ptr].last;
    assign m_axis.tkeep  = '1;
endmodule

// File: tb/tb_fir_out_requant.sv
// Scoreboard bench for fir_out_requant: driver pushes model results, negedge monitor pops and compares.
module tb_fir_out_requant;
    logic clk;
    logic reset;

    fir_out_requant_if #(.DATA_W(32)) s_if ();
    fir_out_requant_if #(.DATA_W(16)) m_if ();

    logic [3:0]  level;
    logic [15:0] sat_count;
    logic [15:0] frame_count;

    fir_out_requant dut (
        .clk         (clk),
        .reset       (reset),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .level       (level),
        .sat_count   (sat_count),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [16:0] exp_q [$];
    int  exp_sat    = 0;
    int  exp_frames = 0;
    int  cyc        = 0;
    bit  rand_rdy   = 0;
    bit  tp_mode    = 0;
    int  tp_pops    = 0;
    int  tp_first   = -1;
    int  tp_last    = -1;
    int  tp_max_lvl = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: floor((v + 2^14) / 2^15) clamped to the Q15 range; bit 16 = saturated.
    function automatic logic [16:0] model(input logic [31:0] d);
        longint v, num, r;
        v   = longint'(signed'(d));
        num = v + 64'sd16384;
        if (num >= 0) r = num / 32768;
        else          r = -((-num + 32767) / 32768);
        if (r > 32767)  return {1'b1, 16'h7FFF};
        if (r < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(r)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: a transfer happens at the next posedge whenever valid&&ready at negedge.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (tp_mode && int'(level) > tp_max_lvl) tp_max_lvl = int'(level);
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got data 0x%0h last %0b expected none",
                             m_if.tdata, m_if.tlast);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    chk("out_data", 64'(m_if.tdata), 64'(e[15:0]));
                    chk("out_last", 64'(m_if.tlast), 64'(e[16]));
                    if (e[16]) exp_frames++;
                end
                if (tp_mode) begin
                    tp_pops++;
                    if (tp_first < 0) tp_first = cyc;
                    tp_last = cyc;
                end
            end
        end
    end

    // Random downstream ready while enabled.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            if (rand_rdy) m_if.tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [31:0] d, input logic l);
        int n;
        logic [16:0] m;
        n = 0;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        @(negedge clk);
        while (!s_if.tready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!s_if.tready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got tready 0 expected 1 for data 0x%0h", d);
        end else begin
            m = model(d);
            exp_q.push_back({l, m[15:0]});
            if (m[16] && exp_sat < 16'hFFFF) exp_sat++;
        end
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || level != 0) && n < 400) begin
            n++;
            @(posedge clk);
        end
        chk("drain_level", 64'(level), 64'd0);
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rnd_vec [8];
    logic [31:0] sat_vec [4];

    initial begin
        rnd_vec[0] = 32'h00004000; rnd_vec[1] = 32'h00003FFF;
        rnd_vec[2] = 32'hFFFFC000; rnd_vec[3] = 32'hFFFFBFFF;
        sat_vec[0] = 32'h3FFF8000; sat_vec[1] = 32'h40000000;
        sat_vec[2] = 32'hC0000000; sat_vec[3] = 32'hBFFF0000;

        reset       = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '1;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        #12;
        chk("rst_s_tready", 64'(s_if.tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_m_tdata",  64'(m_if.tdata),  64'd0);
        chk("rst_m_tlast",  64'(m_if.tlast),  64'd0);
        chk("rst_m_tkeep",  64'(m_if.tkeep),  64'h3);
        chk("rst_level",    64'(level),       64'd0);
        chk("rst_sat",      64'(sat_count),   64'd0);
        chk("rst_frame",    64'(frame_count), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("tready_after_rst", 64'(s_if.tready), 64'd1);

        // Rounding boundaries
        m_if.tready = 1'b1;
        for (int i = 0; i < 4; i++) send(rnd_vec[i], 1'b0);
        drain();
        chk("round_sat", 64'(sat_count), 64'd0);

        // Saturation boundaries
        for (int i = 0; i < 4; i++) send(sat_vec[i], 1'b0);
        drain();
        chk("sat_count", 64'(sat_count), 64'(exp_sat));
        chk("sat_count_2", 64'(sat_count), 64'd2);

        // Backpressure: fill to full
        m_if.tready = 1'b0;
        for (int i = 1; i <= 8; i++) send(32'(i) << 15, 1'b0);
        chk("bp_level_full", 64'(level), 64'd8);
        chk("bp_tready_low", 64'(s_if.tready), 64'd0);
        m_if.tready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_tready_back", 64'(s_if.tready), 64'd1);
        chk("bp_level_7",     64'(level),       64'd7);
        for (int i = 9; i <= 10; i++) send(32'(i) << 15, 1'b0);
        drain();

        // Throughput: back-to-back beats with ready held high
        tp_mode = 1;
        for (int i = 0; i < 100; i++) send($urandom, 1'b0);
        drain();
        tp_mode = 0;
        chk("tp_pops",   64'(tp_pops), 64'd100);
        chk("tp_span",   64'(tp_last - tp_first), 64'd99);
        chk("tp_level_le1", 64'(tp_max_lvl <= 1), 64'd1);

        // Frames of 5 with random downstream ready
        exp_frames = int'(frame_count);
        rand_rdy = 1;
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < 5; b++) send(($urandom_range(0, 65535) - 32768) << 15, 1'(b == 4));
        // Random mixed-magnitude traffic, some saturating
        for (int i = 0; i < 40; i++) begin
            logic [31:0] d;
            d = $urandom;
            d = 32'(signed'(d) >>> $urandom_range(0, 16));
            send(d, 1'($urandom_range(0, 3) == 0));
        end
        @(posedge clk);
        rand_rdy = 0;
        @(posedge clk);
        #1;
        m_if.tready = 1'b1;
        drain();
        chk("frame_count", 64'(frame_count), 64'(exp_frames));
        chk("frame_ge3",   64'(frame_count >= 16'd3), 64'd1);
        chk("sat_final",   64'(sat_count), 64'(exp_sat));

        // Asynchronous reset with data in flight
        m_if.tready = 1'b0;
        for (int i = 0; i < 5; i++) send(32'(i + 20) << 15, 1'(i == 4));
        chk("pre_rst_level", 64'(level), 64'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("mid_rst_level",  64'(level),       64'd0);
        chk("mid_rst_tready", 64'(s_if.tready), 64'd0);
        chk("mid_rst_frame",  64'(frame_count), 64'd0);
        exp_q.delete();
        exp_sat    = 0;
        @(negedge clk);
        reset = 1'b1;
        m_if.tready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_tready", 64'(s_if.tready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_stale", 64'(m_if.tvalid), 64'd0);
        end
        send(32'h00012345, 1'b1);
        drain();
        chk("post_rst_frame", 64'(frame_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
